// File: rtl/bcd_entry_converter.sv
// ---------------------------------------------------------------------------
// bcd_entry_converter
//
// Collects filtered BCD digits into a DIGITS-digit entry register and, on
// request, converts the entered number to binary one digit per clock.
// An invalid digit reported by the upstream filter parks the block in a
// sticky error state that only clear or reset releases.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   in        in   [3:0] BCD digit from the filter
//   in_error  in   filter error flag for `in`
//   load      in   accept `in` this cycle
//   enter     in   start conversion of the entered digits
//   clear     in   discard entry and error
//   digits    out  [4*DIGITS-1:0] entry register, newest digit in [3:0]
//   count     out  [CNT_W-1:0] number of digits entered
//   full      out  count == DIGITS
//   bin       out  [BIN_W-1:0] last conversion result
//   busy      out  conversion in progress
//   done      out  one-cycle pulse when bin is updated
//   error     out  sticky invalid-digit flag
//   overflow  out  one-cycle pulse: load rejected because full
// ---------------------------------------------------------------------------
module bcd_entry_converter #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14,
    parameter int CNT_W  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            in,
    input  logic                  in_error,
    input  logic                  load,
    input  logic                  enter,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   digits,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  overflow
);

    localparam logic [CNT_W-1:0] L_FULL = CNT_W'(DIGITS);
    localparam logic [CNT_W-1:0] L_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_FULL,
        S_CONVERT,
        S_ERROR
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [4*DIGITS-1:0]  r_digits,   w_digits_nxt;
    logic [CNT_W-1:0]     r_count,    w_count_nxt;
    logic [CNT_W-1:0]     r_idx,      w_idx_nxt;
    logic [BIN_W-1:0]     r_acc,      w_acc_nxt;
    logic [BIN_W-1:0]     r_bin,      w_bin_nxt;
    logic                 r_done,     w_done_nxt;
    logic                 r_overflow, w_overflow_nxt;
    logic                 r_full;
    logic                 r_busy;
    logic                 r_error;

    logic [3:0]           w_nib;
    logic [BIN_W-1:0]     w_mac;

    // acc*10 + nib, wrapping modulo 2^BIN_W
    function automatic logic [BIN_W-1:0] f_mac10(input logic [BIN_W-1:0] acc,
                                                  input logic [3:0]       nib);
        return (acc << 3) + (acc << 1) + BIN_W'(nib);
    endfunction

    // Digit currently being folded in; index counts down so the oldest
    // (most significant) digit is consumed first.
    always_comb begin
        w_nib = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == CNT_W'(i)) begin
                w_nib = r_digits[4*i +: 4];
            end
        end
    end

    assign w_mac = f_mac10(r_acc, w_nib);

    // Next-state and next-datapath logic
    always_comb begin
        w_state_nxt    = r_state;
        w_digits_nxt   = r_digits;
        w_count_nxt    = r_count;
        w_idx_nxt      = r_idx;
        w_acc_nxt      = r_acc;
        w_bin_nxt      = r_bin;
        w_done_nxt     = 1'b0;
        w_overflow_nxt = 1'b0;

        if (clear) begin
            w_state_nxt  = S_IDLE;
            w_digits_nxt = '0;
            w_count_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE, S_ENTRY: begin
                    if (enter) begin
                        // enter always wins over load; with nothing entered it is a no-op
                        if (r_state == S_ENTRY) begin
                            w_state_nxt = S_CONVERT;
                            w_acc_nxt   = '0;
                            w_idx_nxt   = r_count - L_ONE;
                        end
                    end else if (load) begin
                        if (in_error) begin
                            w_state_nxt = S_ERROR;
                        end else begin
                            w_digits_nxt = {r_digits[4*DIGITS-5:0], in};
                            w_count_nxt  = r_count + L_ONE;
                            w_state_nxt  = (w_count_nxt == L_FULL) ? S_FULL : S_ENTRY;
                        end
                    end
                end
                S_FULL: begin
                    if (enter) begin
                        w_state_nxt = S_CONVERT;
                        w_acc_nxt   = '0;
                        w_idx_nxt   = r_count - L_ONE;
                    end else if (load) begin
                        if (in_error) begin
                            w_state_nxt = S_ERROR;
                        end else begin
                            w_overflow_nxt = 1'b1;
                        end
                    end
                end
                S_CONVERT: begin
                    w_acc_nxt = w_mac;
                    if (r_idx == '0) begin
                        w_bin_nxt    = w_mac;
                        w_done_nxt   = 1'b1;
                        w_digits_nxt = '0;
                        w_count_nxt  = '0;
                        w_state_nxt  = S_IDLE;
                    end else begin
                        w_idx_nxt = r_idx - L_ONE;
                    end
                end
                S_ERROR: begin
                    w_state_nxt = S_ERROR;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers; status flags are registered from the
    // next-state values so every output changes on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_digits   <= '0;
            r_count    <= '0;
            r_idx      <= '0;
            r_acc      <= '0;
            r_bin      <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_full     <= 1'b0;
            r_busy     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_digits   <= w_digits_nxt;
            r_count    <= w_count_nxt;
            r_idx      <= w_idx_nxt;
            r_acc      <= w_acc_nxt;
            r_bin      <= w_bin_nxt;
            r_done     <= w_done_nxt;
            r_overflow <= w_overflow_nxt;
            r_full     <= (w_count_nxt == L_FULL);
            r_busy     <= (w_state_nxt == S_CONVERT);
            r_error    <= (w_state_nxt == S_ERROR);
        end
    end

    assign digits   = r_digits;
    assign count    = r_count;
    assign full     = r_full;
    assign bin      = r_bin;
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_bcd_entry_converter.sv
// ---------------------------------------------------------------------------
// tb_bcd_entry_converter
//
// Directed stimulus against bcd_entry_converter. A behavioural model keeps
// the entered digits as a queue and a conversion as a countdown to a
// precomputed decimal value; every cycle the DUT outputs are compared with
// it. Hand-computed literal checks pin the key scenarios.
// ---------------------------------------------------------------------------
module tb_bcd_entry_converter;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;
    localparam int CNT_W  = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [3:0]           t_in;
    logic                 t_in_error;
    logic                 t_load;
    logic                 t_enter;
    logic                 t_clear;
    logic [4*DIGITS-1:0]  digits;
    logic [CNT_W-1:0]     count;
    logic                 full;
    logic [BIN_W-1:0]     bin;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic                 overflow;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    bcd_entry_converter #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (t_in),
        .in_error (t_in_error),
        .load     (t_load),
        .enter    (t_enter),
        .clear    (t_clear),
        .digits   (digits),
        .count    (count),
        .full     (full),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_q[$];          // entered digits, oldest first
    bit m_err      = 1'b0;
    int m_bin      = 0;
    int m_left     = 0;  // cycles of conversion remaining
    int m_target   = 0;
    bit m_done     = 1'b0;
    bit m_ovf      = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            m_done = 1'b0;
            m_ovf  = 1'b0;
            if (reset) begin
                m_q.delete();
                m_err  = 1'b0;
                m_bin  = 0;
                m_left = 0;
            end else if (t_clear) begin
                m_q.delete();
                m_err  = 1'b0;
                m_left = 0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_bin  = m_target;
                    m_done = 1'b1;
                    m_q.delete();
                end
            end else if (m_err) begin
                // parked until clear
            end else if (t_enter) begin
                if (m_q.size() > 0) begin
                    m_target = 0;
                    foreach (m_q[i]) m_target = m_target * 10 + m_q[i];
                    m_target = m_target % (1 << BIN_W);
                    m_left   = m_q.size();
                end
            end else if (t_load) begin
                if (t_in_error) m_err = 1'b1;
                else if (m_q.size() == DIGITS) m_ovf = 1'b1;
                else m_q.push_back(int'(t_in));
            end
        end
    end

    function automatic int exp_digits();
        int d = 0;
        foreach (m_q[i]) d = (d << 4) | m_q[i];
        return d;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("m.digits",   int'(digits),   exp_digits());
                chk("m.count",    int'(count),    m_q.size());
                chk("m.full",     int'(full),     int'(m_q.size() == DIGITS));
                chk("m.bin",      int'(bin),      m_bin);
                chk("m.busy",     int'(busy),     int'(m_left > 0));
                chk("m.done",     int'(done),     int'(m_done));
                chk("m.error",    int'(error),    int'(m_err));
                chk("m.overflow", int'(overflow), int'(m_ovf));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit l, input bit e, input bit c,
                        input logic [3:0] d, input bit er);
        t_load     = l;
        t_enter    = e;
        t_clear    = c;
        t_in       = d;
        t_in_error = er;
        @(posedge clk);
        #1;
        t_load     = 1'b0;
        t_enter    = 1'b0;
        t_clear    = 1'b0;
        t_in_error = 1'b0;
        t_in       = 4'(($urandom_range(0, 15)));
    endtask

    task automatic ld(input logic [3:0] d);
        step(1'b1, 1'b0, 1'b0, d, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        t_in       = 4'd0;
        t_in_error = 1'b0;
        t_load     = 1'b0;
        t_enter    = 1'b0;
        t_clear    = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        // reset state
        chk("rst.digits", int'(digits), 0);
        chk("rst.count",  int'(count),  0);
        chk("rst.bin",    int'(bin),    0);
        chk("rst.busy",   int'(busy),   0);

        // 1,9,8,4 then enter
        ld(4'd1); ld(4'd9); ld(4'd8);
        chk("e1984.full3", int'(full), 0);
        ld(4'd4);
        chk("e1984.digits", int'(digits), 16'h1984);
        chk("e1984.full",   int'(full),   1);
        chk("e1984.count",  int'(count),  4);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("e1984.busy0", int'(busy), 1);
        idle(3);
        chk("e1984.busy3", int'(busy), 1);
        chk("e1984.nodone", int'(done), 0);
        idle(1);
        chk("e1984.done",   int'(done),   1);
        chk("e1984.bin",    int'(bin),    14'h7C0);
        chk("e1984.count0", int'(count),  0);
        chk("e1984.dig0",   int'(digits), 0);
        idle(1);
        chk("e1984.pulse", int'(done), 0);

        // single digit, then empty enter
        ld(4'd7);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("e7.busy", int'(busy), 1);
        idle(1);
        chk("e7.done", int'(done), 1);
        chk("e7.bin",  int'(bin),  7);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("empty.busy", int'(busy), 0);
        idle(1);
        chk("empty.done", int'(done), 0);
        chk("empty.bin",  int'(bin),  7);

        // 9999 with back-to-back overflow
        ld(4'd9); ld(4'd9); ld(4'd9); ld(4'd9);
        ld(4'd5);
        chk("ovf.pulse1", int'(overflow), 1);
        chk("ovf.digits", int'(digits),   16'h9999);
        ld(4'd5);
        chk("ovf.pulse2", int'(overflow), 1);
        idle(1);
        chk("ovf.low", int'(overflow), 0);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        idle(4);
        chk("e9999.done", int'(done), 1);
        chk("e9999.bin",  int'(bin),  9999);

        // sticky error
        ld(4'd3);
        step(1'b1, 1'b0, 1'b0, 4'd12, 1'b1);
        chk("err.set",    int'(error),  1);
        chk("err.digits", int'(digits), 3);
        ld(4'd6);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        idle(2);
        chk("err.hold",   int'(error),  1);
        chk("err.digit2", int'(digits), 3);
        chk("err.nobusy", int'(busy),   0);
        step(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        chk("err.clr",   int'(error), 0);
        chk("err.cnt0",  int'(count), 0);
        ld(4'd8);
        chk("err.reuse", int'(digits), 8);
        step(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);

        // load and enter together: load dropped
        ld(4'd4); ld(4'd2);
        step(1'b1, 1'b1, 1'b0, 4'd5, 1'b0);
        chk("e42.busy",   int'(busy),   1);
        chk("e42.digits", int'(digits), 16'h0042);
        idle(2);
        chk("e42.done", int'(done), 1);
        chk("e42.bin",  int'(bin),  42);

        // clear on second convert cycle
        ld(4'd1); ld(4'd2); ld(4'd3);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        idle(1);
        step(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        chk("abort.busy", int'(busy), 0);
        chk("abort.done", int'(done), 0);
        chk("abort.bin",  int'(bin),  42);
        idle(4);
        chk("abort.late", int'(bin),  42);

        // reset mid-entry
        ld(4'd5); ld(4'd6);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("rst2.digits", int'(digits), 0);
        chk("rst2.count",  int'(count),  0);
        chk("rst2.bin",    int'(bin),    0);
        chk("rst2.error",  int'(error),  0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
